// File: rtl/mdu_defs.sv
// ---------------------------------------------------------------------------
// mdu_defs
// Shared definitions for the iterative multiply/divide unit: operation
// encoding and controller state encoding.
// ---------------------------------------------------------------------------
package mdu_defs;

    localparam logic MDU_OP_MULT = 1'b0;
    localparam logic MDU_OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } mduState_e;

endpackage

// File: rtl/cond_negate.sv
// ---------------------------------------------------------------------------
// cond_negate
// Conditional two's-complement negation: dataOut = neg ? -dataIn : dataIn.
// Used for operand magnitudes and for the sign correction of results.
//   dataIn  [WIDTH-1:0]  value to pass or negate
//   neg                  1 = negate
//   dataOut [WIDTH-1:0]  result
// ---------------------------------------------------------------------------
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] dataIn,
    input  logic             neg,
    output logic [WIDTH-1:0] dataOut
);

    assign dataOut = neg ? (~dataIn + {{(WIDTH-1){1'b0}}, 1'b1}) : dataIn;

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative multicycle multiply/divide unit (MULT/MULTU/DIV/DIVU).
// Works on operand magnitudes; the result sign is applied in FINISH.
//   clk        rising-edge clock
//   reset      asynchronous, active-low
//   start      launch request, sampled only in IDLE
//   abort      cancels an operation in LOAD/RUN
//   op         0 = multiply, 1 = divide
//   sign_en    1 = signed operands
//   a, b       multiplicand/dividend, multiplier/divisor
//   busy       high in LOAD, RUN and FINISH
//   done       one-cycle pulse when hi/lo are updated
//   div_zero   one-cycle pulse with done for divide by zero
//   hi, lo     mult: product high/low; div: remainder/quotient
//
// state  | meaning
// IDLE   | waiting for start; operands and signs latched on start
// LOAD   | divide-by-zero check, accumulator/counter initialised
// RUN    | one shift-add or restoring-subtract step per cycle, WIDTH steps
// FINISH | sign correction, hi/lo written, done pulsed
// ---------------------------------------------------------------------------
module mult_div_unit
    import mdu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             op,
    input  logic             sign_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mduState_e stateQ, stateD;

    logic               opQ;
    logic               signEnQ;
    logic               aSignQ;
    logic               bSignQ;
    logic [WIDTH-1:0]   opAQ;
    logic [WIDTH-1:0]   opBQ;
    logic [2*WIDTH-1:0] accQ;
    logic [CNT_W-1:0]   cntQ;

    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH+1:0]   addA, addB, addSum;
    logic [2*WIDTH-1:0] accNext;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix, remFix;
    logic               qBit;
    logic [WIDTH-1:0]   newRem;
    logic               divByZero;
    logic               mulNeg, quotNeg, remNeg;

    cond_negate #(.WIDTH(WIDTH)) uAbsA (
        .dataIn(a), .neg(sign_en & a[WIDTH-1]), .dataOut(absA)
    );
    cond_negate #(.WIDTH(WIDTH)) uAbsB (
        .dataIn(b), .neg(sign_en & b[WIDTH-1]), .dataOut(absB)
    );

    assign mulNeg  = signEnQ & (aSignQ ^ bSignQ);
    assign quotNeg = signEnQ & (aSignQ ^ bSignQ);
    assign remNeg  = signEnQ & aSignQ;

    cond_negate #(.WIDTH(2*WIDTH)) uProdFix (
        .dataIn(accQ), .neg(mulNeg), .dataOut(prodFix)
    );
    cond_negate #(.WIDTH(WIDTH)) uQuotFix (
        .dataIn(accQ[WIDTH-1:0]), .neg(quotNeg), .dataOut(quotFix)
    );
    cond_negate #(.WIDTH(WIDTH)) uRemFix (
        .dataIn(accQ[2*WIDTH-1:WIDTH]), .neg(remNeg), .dataOut(remFix)
    );

    assign divByZero = (opQ == MDU_OP_DIV) && (opBQ == '0);
    assign busy      = (stateQ != IDLE);

    // Shared adder. Multiply adds the multiplicand to the upper half;
    // divide subtracts the divisor from the upper half shifted left by one,
    // which needs WIDTH+1 bits since the partial remainder can exceed WIDTH.
    always_comb begin
        if (opQ == MDU_OP_MULT) begin
            addA = {2'b00, accQ[2*WIDTH-1:WIDTH]};
            addB = {2'b00, opAQ};
        end else begin
            addA = {1'b0, accQ[2*WIDTH-1:WIDTH-1]};
            addB = ~{2'b00, opBQ};
        end
        addSum = addA + addB + {{(WIDTH+1){1'b0}}, opQ};
    end

    always_comb begin
        qBit   = ~addSum[WIDTH+1];
        newRem = qBit ? addSum[WIDTH-1:0] : accQ[2*WIDTH-2:WIDTH-1];
        if (opQ == MDU_OP_MULT) begin
            accNext = accQ[0] ? {addSum[WIDTH:0], accQ[WIDTH-1:1]}
                              : {1'b0, accQ[2*WIDTH-1:1]};
        end else begin
            accNext = {newRem, accQ[WIDTH-2:0], qBit};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE: begin
                if (start) stateD = LOAD;
            end
            LOAD: begin
                if (abort)          stateD = IDLE;
                else if (divByZero) stateD = FINISH;
                else                stateD = RUN;
            end
            RUN: begin
                if (abort)                 stateD = IDLE;
                else if (cntQ == LAST_CNT) stateD = FINISH;
            end
            FINISH: begin
                stateD = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opQ      <= 1'b0;
            signEnQ  <= 1'b0;
            aSignQ   <= 1'b0;
            bSignQ   <= 1'b0;
            opAQ     <= '0;
            opBQ     <= '0;
            accQ     <= '0;
            cntQ     <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (stateQ)
                IDLE: begin
                    if (start) begin
                        opQ     <= op;
                        signEnQ <= sign_en;
                        aSignQ  <= a[WIDTH-1];
                        bSignQ  <= b[WIDTH-1];
                        opAQ    <= absA;
                        opBQ    <= absB;
                    end
                end
                LOAD: begin
                    // Multiply shifts the multiplier out of the low half;
                    // divide shifts the dividend out of it.
                    accQ <= {{WIDTH{1'b0}}, (opQ == MDU_OP_MULT) ? opBQ : opAQ};
                    cntQ <= '0;
                end
                RUN: begin
                    accQ <= accNext;
                    cntQ <= cntQ + CNT_W'(1);
                end
                FINISH: begin
                    done <= 1'b1;
                    if (divByZero) begin
                        div_zero <= 1'b1;
                    end else if (opQ == MDU_OP_MULT) begin
                        {hi, lo} <= prodFix;
                    end else begin
                        hi <= remFix;
                        lo <= quotFix;
                    end
                end
            endcase
        end
    end

endmodule
